// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one req/ack memory bus between IF and MEM with MEM priority, flush drain and timeout
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_err,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_err,
    output logic        bus_cyc,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stallreq_from_if,
    output logic        stallreq_from_mem
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, BUSY_MEM, BUSY_IF, DRAIN} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic tmo, fin, if_fin, mem_fin, grant, to_mem;
    // ack wins over a timeout landing on the same cycle
    assign tmo = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    assign fin = bus_ack | tmo;
    assign grant = (state == IDLE) && (state_n != IDLE);
    assign to_mem = state_n == BUSY_MEM;
    assign stallreq_from_if = if_req & ~if_done;
    assign stallreq_from_mem = mem_req & ~mem_done;
    always_comb begin
        state_n = state;
        if_fin = 1'b0;
        mem_fin = 1'b0;
        case (state)
            IDLE:     state_n = flush ? IDLE : mem_req ? BUSY_MEM : if_req ? BUSY_IF : IDLE;
            BUSY_MEM: begin
                state_n = fin ? IDLE : BUSY_MEM;
                mem_fin = fin;
            end
            BUSY_IF:  begin
                state_n = fin ? IDLE : flush ? DRAIN : BUSY_IF;
                if_fin = fin & ~flush;
            end
            DRAIN:    state_n = fin ? IDLE : DRAIN;
            default:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            bus_cyc <= 1'b0;
            bus_we <= 1'b0;
            bus_sel <= '0;
            bus_addr <= '0;
            bus_wdata <= '0;
            if_rdata <= '0;
            if_done <= 1'b0;
            if_err <= 1'b0;
            mem_rdata <= '0;
            mem_done <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= (state_n != state || state == IDLE) ? '0 : cnt + CW'(1);
            bus_cyc <= state_n != IDLE;
            if (grant) begin
                bus_we <= to_mem & mem_we;
                bus_sel <= to_mem ? mem_sel : 4'hf;
                bus_addr <= to_mem ? mem_addr : if_addr;
                bus_wdata <= to_mem ? mem_wdata : '0;
            end
            if_done <= if_fin;
            if_err <= if_fin & ~bus_ack;
            mem_done <= mem_fin;
            mem_err <= mem_fin & ~bus_ack;
            if (if_fin) if_rdata <= bus_ack ? bus_rdata : '0;
            if (mem_fin) mem_rdata <= (bus_ack & ~bus_we) ? bus_rdata : '0;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized transaction checks of bus_arbiter against a transaction-level model
module tb_bus_arbiter;
    localparam int TMO = 8;
    logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, bus_ack = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, bus_rdata = '0;
    logic [3:0] mem_sel = '0;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic if_done, if_err, mem_done, mem_err, bus_cyc, bus_we;
    logic [3:0] bus_sel;
    logic stallreq_from_if, stallreq_from_mem;
    int vectors = 0, errs = 0;
    logic [31:0] exp_if_rd = '0, exp_mem_rd = '0;

    bus_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err),
        .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete access from IDLE; ack arrives dly cycles after the first bus_cyc cycle
    task automatic do_txn(input bit m, input bit we, input bit fl, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                          input int dly);
        logic e;
        if (m) begin
            mem_we = we; mem_sel = sel; mem_addr = addr; mem_wdata = wd; mem_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        tick;
        chk("grant_cyc", bus_cyc, 1);
        chk("grant_addr", bus_addr, addr);
        chk("grant_we", bus_we, m & we);
        chk("grant_sel", bus_sel, m ? sel : 4'hf);
        if (m && we) chk("grant_wdata", bus_wdata, wd);
        chk("stall_on", m ? stallreq_from_mem : stallreq_from_if, 1);
        flush = fl & m;
        if (dly < TMO) begin
            repeat (dly) tick;
            bus_ack = 1'b1; bus_rdata = rd;
            tick;
            bus_ack = 1'b0;
            if (m) exp_mem_rd = we ? 32'h0 : rd; else exp_if_rd = rd;
            e = 1'b0;
        end else begin
            for (int i = 1; i < TMO; i++) begin
                tick;
                chk("tmo_hold", bus_cyc, 1);
            end
            tick;
            if (m) exp_mem_rd = '0; else exp_if_rd = '0;
            e = 1'b1;
        end
        flush = 1'b0;
        chk("done", m ? mem_done : if_done, 1);
        chk("err", m ? mem_err : if_err, e);
        chk("other_done", m ? if_done : mem_done, 0);
        chk("cyc_off", bus_cyc, 0);
        chk("stall_off", m ? stallreq_from_mem : stallreq_from_if, 0);
        chk("if_rdata", if_rdata, exp_if_rd);
        chk("mem_rdata", mem_rdata, exp_mem_rd);
        mem_req = 1'b0; if_req = 1'b0;
        tick;
        chk("done_pulse", m ? mem_done : if_done, 0);
        chk("idle_gap", bus_cyc, 0);
    endtask

    initial begin
        tick;
        chk("rst_cyc", bus_cyc, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_done", mem_done, 0);
        rst = 1'b1;
        tick;
        // fetch with ack two cycles after grant
        do_txn(0, 0, 0, 4'h0, 32'h100, 32'h0, 32'h3C010000, 2);
        // simultaneous requests: MEM first, idle cycle, then IF
        mem_addr = 32'h2000; mem_we = 1'b0; mem_sel = 4'hf; if_addr = 32'h100;
        mem_req = 1'b1; if_req = 1'b1;
        tick;
        chk("both_first", bus_addr, 32'h2000);
        chk("both_stall_if1", stallreq_from_if, 1);
        bus_ack = 1'b1; bus_rdata = 32'h11112222;
        tick;
        bus_ack = 1'b0;
        exp_mem_rd = 32'h11112222;
        chk("both_mem_done", mem_done, 1);
        chk("both_gap", bus_cyc, 0);
        chk("both_stall_if2", stallreq_from_if, 1);
        chk("both_mem_rdata", mem_rdata, exp_mem_rd);
        mem_req = 1'b0;
        tick;
        chk("both_second_cyc", bus_cyc, 1);
        chk("both_second", bus_addr, 32'h100);
        chk("both_stall_if3", stallreq_from_if, 1);
        bus_ack = 1'b1; bus_rdata = 32'h33334444;
        tick;
        bus_ack = 1'b0;
        exp_if_rd = 32'h33334444;
        chk("both_if_done", if_done, 1);
        chk("both_if_rdata", if_rdata, exp_if_rd);
        if_req = 1'b0;
        tick;
        // store
        do_txn(1, 1, 0, 4'b0011, 32'h40, 32'hDEADBEEF, 32'h12345678, 1);
        // flush one cycle into a fetch, ack three cycles later
        if_addr = 32'h200; if_req = 1'b1;
        tick;
        chk("fl_grant", bus_cyc, 1);
        flush = 1'b1;
        tick;
        flush = 1'b0; if_req = 1'b0;
        chk("fl_drain1", bus_cyc, 1);
        tick;
        chk("fl_drain2", bus_cyc, 1);
        tick;
        chk("fl_drain3", bus_cyc, 1);
        bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
        tick;
        bus_ack = 1'b0;
        chk("fl_cyc_off", bus_cyc, 0);
        chk("fl_no_done", if_done, 0);
        chk("fl_rdata", if_rdata, exp_if_rd);
        tick;
        chk("fl_no_done2", if_done, 0);
        do_txn(0, 0, 0, 4'h0, 32'h204, 32'h0, 32'hCAFE0001, 0);
        // flush and ack together in BUSY_IF
        if_addr = 32'h400; if_req = 1'b1;
        tick;
        flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h55555555;
        tick;
        flush = 1'b0; bus_ack = 1'b0; if_req = 1'b0;
        chk("flack_cyc", bus_cyc, 0);
        chk("flack_done", if_done, 0);
        chk("flack_rdata", if_rdata, exp_if_rd);
        tick;
        // flush in IDLE blocks the grant; ack in IDLE is ignored
        flush = 1'b1; if_req = 1'b1;
        tick;
        chk("idle_flush", bus_cyc, 0);
        flush = 1'b0; if_req = 1'b0; bus_ack = 1'b1;
        tick;
        bus_ack = 1'b0;
        chk("idle_ack_cyc", bus_cyc, 0);
        chk("idle_ack_done", if_done | mem_done, 0);
        tick;
        // flush during MEM has no effect
        do_txn(1, 0, 1, 4'hf, 32'h80, 32'h0, 32'h0BADF00D, 3);
        // timeout
        do_txn(1, 0, 0, 4'hf, 32'h3000, 32'h0, 32'h0, 20);
        do_txn(0, 0, 0, 4'h0, 32'h500, 32'h0, 32'h0, TMO);
        do_txn(1, 0, 0, 4'hf, 32'h3004, 32'h0, 32'h77778888, TMO - 1);
        // asynchronous reset mid BUSY_MEM
        mem_addr = 32'h6000; mem_we = 1'b0; mem_req = 1'b1;
        tick;
        chk("rst_mid_cyc", bus_cyc, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_cyc", bus_cyc, 0);
        chk("rst_async_addr", bus_addr, 0);
        chk("rst_async_mem_rdata", mem_rdata, 0);
        chk("rst_async_if_rdata", if_rdata, 0);
        exp_if_rd = '0; exp_mem_rd = '0;
        mem_req = 1'b0;
        #2 rst = 1'b1;
        tick;
        chk("rst_no_done", mem_done, 0);
        do_txn(0, 0, 0, 4'h0, 32'h300, 32'h0, 32'hABCD0123, 1);
        // randomized transactions
        for (int n = 0; n < 40; n++) begin
            automatic bit m = 1'($urandom_range(0, 1));
            automatic bit we = 1'($urandom_range(0, 1));
            automatic bit fl = 1'($urandom_range(0, 1));
            automatic logic [3:0] sel = 4'($urandom_range(1, 15));
            automatic int dly = (n % 7 == 6) ? $urandom_range(TMO, TMO + 3) : $urandom_range(0, TMO - 1);
            do_txn(m, we, fl, sel, $urandom, $urandom, $urandom, dly);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
